// File: rtl/pipe_pkg.sv
// Shared pipeline types: forward select encoding and hazard FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand EX bypass comparator; MEM beats WB, x0 is never forwarded.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output fwd_sel_e          sel
);

  // Priority compare of the EX source against the younger MEM result first
  always_comb begin
    sel = FWD_RF;
    if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding selects, load-use detect, multi-cycle stall FSM and stall counter.
module forward_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MC_LAT  = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*REG_AW-1:0] ID_RS_i,
  input  logic [NUM_SRC-1:0]        ID_RSUsed_i,
  input  logic [NUM_SRC*REG_AW-1:0] EX_RS_i,
  input  logic [REG_AW-1:0]         EX_RD_i,
  input  logic                      EX_MemRead_i,
  input  logic                      EX_MultiCycle_i,
  input  logic [REG_AW-1:0]         MEM_RD_i,
  input  logic                      MEM_RegWrite_i,
  input  logic [REG_AW-1:0]         WB_RD_i,
  input  logic                      WB_RegWrite_i,
  output logic [NUM_SRC*2-1:0]      Forward_o,
  output logic                      PCWrite_o,
  output logic                      IF_ID_Write_o,
  output logic                      ID_EX_Flush_o,
  output logic                      EX_Hold_o,
  output logic [CNT_W-1:0]          StallCnt_o
);

  localparam int unsigned CW = $clog2(MC_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

  hz_state_e              state;
  logic [CW-1:0]          cnt;
  logic [NUM_SRC*2-1:0]   fwd_raw;
  logic                   luse;
  logic                   hold;

  // One comparator per source operand
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .ex_rs  (EX_RS_i[k*REG_AW +: REG_AW]),
      .mem_rd (MEM_RD_i),
      .mem_we (MEM_RegWrite_i),
      .wb_rd  (WB_RD_i),
      .wb_we  (WB_RegWrite_i),
      .sel    (fwd_raw[k*2 +: 2])
    );
  end

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    logic match;
    match = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (ID_RSUsed_i[k] && (ID_RS_i[k*REG_AW +: REG_AW] == EX_RD_i)) begin
        match = 1'b1;
      end
    end
    luse = EX_MemRead_i && (EX_RD_i != '0) && match;
  end

  // Hold covers the entry cycle plus all but the last BUSY cycle; reset kills it
  always_comb begin
    hold = 1'b0;
    if (rst_i) begin
      hold = ((state == IDLE) && EX_MultiCycle_i) || ((state == BUSY) && (cnt != '0));
    end
  end

  // Pipe control: multi-cycle hold outranks load-use
  always_comb begin
    Forward_o     = '0;
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    ID_EX_Flush_o = 1'b0;
    EX_Hold_o     = 1'b0;
    if (rst_i) begin
      Forward_o = fwd_raw;
      if (hold) begin
        EX_Hold_o     = 1'b1;
        PCWrite_o     = 1'b0;
        IF_ID_Write_o = 1'b0;
      end else if (luse) begin
        PCWrite_o     = 1'b0;
        IF_ID_Write_o = 1'b0;
        ID_EX_Flush_o = 1'b1;
      end
    end
  end

  // Multi-cycle occupancy FSM with residual-cycle down-counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (EX_MultiCycle_i) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      StallCnt_o <= '0;
    end else if (!PCWrite_o && (StallCnt_o != '1)) begin
      StallCnt_o <= StallCnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit (REG_AW=5, NUM_SRC=2, MC_LAT=4, CNT_W=4).
module tb_forward_hazard_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned MC_LAT  = 4;
  localparam int unsigned CNT_W   = 4;

  logic                      clk_i;
  logic                      rst_i;
  logic [NUM_SRC*REG_AW-1:0] ID_RS_i;
  logic [NUM_SRC-1:0]        ID_RSUsed_i;
  logic [NUM_SRC*REG_AW-1:0] EX_RS_i;
  logic [REG_AW-1:0]         EX_RD_i;
  logic                      EX_MemRead_i;
  logic                      EX_MultiCycle_i;
  logic [REG_AW-1:0]         MEM_RD_i;
  logic                      MEM_RegWrite_i;
  logic [REG_AW-1:0]         WB_RD_i;
  logic                      WB_RegWrite_i;
  logic [NUM_SRC*2-1:0]      Forward_o;
  logic                      PCWrite_o;
  logic                      IF_ID_Write_o;
  logic                      ID_EX_Flush_o;
  logic                      EX_Hold_o;
  logic [CNT_W-1:0]          StallCnt_o;

  int n_cmp = 0;
  int n_err = 0;

  forward_hazard_unit #(
    .REG_AW (REG_AW),
    .NUM_SRC(NUM_SRC),
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ID_RS_i        (ID_RS_i),
    .ID_RSUsed_i    (ID_RSUsed_i),
    .EX_RS_i        (EX_RS_i),
    .EX_RD_i        (EX_RD_i),
    .EX_MemRead_i   (EX_MemRead_i),
    .EX_MultiCycle_i(EX_MultiCycle_i),
    .MEM_RD_i       (MEM_RD_i),
    .MEM_RegWrite_i (MEM_RegWrite_i),
    .WB_RD_i        (WB_RD_i),
    .WB_RegWrite_i  (WB_RegWrite_i),
    .Forward_o      (Forward_o),
    .PCWrite_o      (PCWrite_o),
    .IF_ID_Write_o  (IF_ID_Write_o),
    .ID_EX_Flush_o  (ID_EX_Flush_o),
    .EX_Hold_o      (EX_Hold_o),
    .StallCnt_o     (StallCnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    ID_RS_i         = '0;
    ID_RSUsed_i     = '0;
    EX_RS_i         = '0;
    EX_RD_i         = '0;
    EX_MemRead_i    = 1'b0;
    EX_MultiCycle_i = 1'b0;
    MEM_RD_i        = '0;
    MEM_RegWrite_i  = 1'b0;
    WB_RD_i         = '0;
    WB_RegWrite_i   = 1'b0;
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_luse();
    EX_MemRead_i = 1'b1;
    EX_RD_i      = 5'd3;
    ID_RS_i      = {5'd3, 5'd0};
    ID_RSUsed_i  = 2'b10;
  endtask

  initial begin
    rst_i = 1'b0;
    clr_in();
    // Reset forcing with live forwarding and hold requests on the inputs
    MEM_RD_i = 5'd5; MEM_RegWrite_i = 1'b1; EX_RS_i = {5'd0, 5'd5};
    EX_MultiCycle_i = 1'b1;
    #3;
    check("rst_fwd",   32'(Forward_o), 32'h0);
    check("rst_pcw",   32'(PCWrite_o), 32'h1);
    check("rst_ifid",  32'(IF_ID_Write_o), 32'h1);
    check("rst_flush", 32'(ID_EX_Flush_o), 32'h0);
    check("rst_hold",  32'(EX_Hold_o), 32'h0);
    check("rst_cnt",   32'(StallCnt_o), 32'h0);
    step();
    step();
    clr_in();
    rst_i = 1'b1;
    #1;

    // MEM/WB forwarding priority
    MEM_RD_i = 5'd5; MEM_RegWrite_i = 1'b1; WB_RD_i = 5'd5; WB_RegWrite_i = 1'b1;
    EX_RS_i = {5'd0, 5'd5};
    #1 check("fwd_mem_prio", 32'(Forward_o), 32'h2);
    MEM_RegWrite_i = 1'b0;
    #1 check("fwd_wb", 32'(Forward_o), 32'h1);
    clr_in();
    #1 check("fwd_rf_zero", 32'(Forward_o), 32'h0);
    // Write-enable and x0 gating
    MEM_RD_i = 5'd7; MEM_RegWrite_i = 1'b0; EX_RS_i = {5'd7, 5'd0};
    #1 check("fwd_mem_we_off", 32'(Forward_o), 32'h0);
    clr_in();
    WB_RD_i = 5'd0; WB_RegWrite_i = 1'b1; EX_RS_i = {5'd0, 5'd0};
    #1 check("fwd_wb_x0", 32'(Forward_o), 32'h0);
    // Independent per-operand selects
    MEM_RD_i = 5'd4; MEM_RegWrite_i = 1'b1; WB_RD_i = 5'd9; WB_RegWrite_i = 1'b1;
    EX_RS_i = {5'd4, 5'd9};
    #1 check("fwd_two_ops", 32'(Forward_o), 32'h9);
    check("fwd_no_stall", 32'(PCWrite_o), 32'h1);
    clr_in();
    step();
    check("cnt_idle", 32'(StallCnt_o), 32'h0);

    // Load-use: one stall cycle, then MEM forwarding covers it
    set_luse();
    #1;
    check("lu_pcw",   32'(PCWrite_o), 32'h0);
    check("lu_ifid",  32'(IF_ID_Write_o), 32'h0);
    check("lu_flush", 32'(ID_EX_Flush_o), 32'h1);
    check("lu_hold",  32'(EX_Hold_o), 32'h0);
    step();
    check("lu_cnt", 32'(StallCnt_o), 32'h1);
    clr_in();
    MEM_RD_i = 5'd3; MEM_RegWrite_i = 1'b1; EX_RS_i = {5'd3, 5'd0};
    #1;
    check("lu_after_fwd", 32'(Forward_o), 32'h8);
    check("lu_after_pcw", 32'(PCWrite_o), 32'h1);
    clr_in();
    set_luse();
    ID_RSUsed_i = 2'b01;
    #1;
    check("lu_unused_pcw",   32'(PCWrite_o), 32'h1);
    check("lu_unused_flush", 32'(ID_EX_Flush_o), 32'h0);
    clr_in();
    EX_MemRead_i = 1'b1; EX_RD_i = 5'd0; ID_RS_i = '0; ID_RSUsed_i = 2'b11;
    #1 check("lu_x0", 32'(ID_EX_Flush_o), 32'h0);
    clr_in();
    step();
    check("lu_cnt_hold", 32'(StallCnt_o), 32'h1);

    // Single multi-cycle op, with a simultaneous load-use in the entry cycle
    EX_MultiCycle_i = 1'b1;
    set_luse();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mc_hold_%0d", i), 32'(EX_Hold_o), (i < 3) ? 32'h1 : 32'h0);
      check($sformatf("mc_pcw_%0d", i),  32'(PCWrite_o), (i < 3) ? 32'h0 : 32'h1);
      if (i == 0) begin
        check("mc_over_lu_flush", 32'(ID_EX_Flush_o), 32'h0);
        EX_MemRead_i = 1'b0; EX_RD_i = '0; ID_RS_i = '0; ID_RSUsed_i = '0;
      end
      step();
    end
    EX_MultiCycle_i = 1'b0;
    #1;
    check("mc_cnt", 32'(StallCnt_o), 32'h4);
    check("mc_idle_hold", 32'(EX_Hold_o), 32'h0);

    // Back-to-back ops: no dead cycle between them
    EX_MultiCycle_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("b2b_hold_%0d", i), 32'(EX_Hold_o), ((i % 4) != 3) ? 32'h1 : 32'h0);
      step();
    end
    EX_MultiCycle_i = 1'b0;
    #1 check("b2b_cnt", 32'(StallCnt_o), 32'ha);

    // Reset asserted mid-BUSY aborts the hold at once
    EX_MultiCycle_i = 1'b1;
    step();
    check("rb_busy_hold", 32'(EX_Hold_o), 32'h1);
    MEM_RD_i = 5'd6; MEM_RegWrite_i = 1'b1; EX_RS_i = {5'd0, 5'd6};
    rst_i = 1'b0;
    #1;
    check("rb_hold", 32'(EX_Hold_o), 32'h0);
    check("rb_pcw",  32'(PCWrite_o), 32'h1);
    check("rb_fwd",  32'(Forward_o), 32'h0);
    check("rb_cnt",  32'(StallCnt_o), 32'h0);
    step();
    clr_in();
    rst_i = 1'b1;
    #1 check("rb_idle_hold", 32'(EX_Hold_o), 32'h0);
    step();

    // Counter saturation at 2^CNT_W-1
    set_luse();
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check("sat_cnt", 32'(StallCnt_o), 32'hf);
    clr_in();
    step();
    check("sat_cnt_stays", 32'(StallCnt_o), 32'hf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
